// File: rtl/mult_div_unit_pkg.sv
// Shared mult/div definitions: mdOp codes, MFHI/MFLO select, FSM states, accumulate modes.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU family as long operations.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MDNOP = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } mdOp_e;

    localparam logic MFSEL_LO = 1'b0;
    localparam logic MFSEL_HI = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } accMode_e;

    function automatic logic isLongOp(input mdOp_e op);
        case (op)
            MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mult_div_unit_md_counter.sv
// Busy-cycle down-counter: loads N on accept, decrements to zero, flags done at count 1.
module md_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; results are computed at accept and committed after N busy cycles.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate family.
//
// state | meaning
// IDLE  | no long op in flight, busy=0, MTHI/MTLO and new ops accepted
// RUN   | long op in flight, busy=1, commit of pending result on counter done
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  mdOp,
    input  logic        start,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdState_e     state, stateNext;
    mdOp_e        op;
    logic         accept, longAccept, cntDone;
    logic [CNT_W-1:0] cycles;
    logic [63:0]  prodS, prodU;
    logic [31:0]  divN, divD, quot, rem;
    logic         signedDiv;
    logic [31:0]  pendHi, pendLo, nextPendHi, nextPendLo;
    logic         pendWrite, nextPendWrite;
    accMode_e     pendAcc, nextPendAcc;

    always_comb begin
        op         = mdOp_e'(mdOp);
        accept     = start & ~req & ~busy;
        longAccept = accept & isLongOp(op);

        prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prodU = {32'b0, srcA} * {32'b0, srcB};

        // Signed divide runs on magnitudes so INT_MIN / -1 simply wraps.
        signedDiv = (op == DIV);
        divN = (signedDiv && srcA[31]) ? -srcA : srcA;
        divD = (signedDiv && srcB[31]) ? -srcB : srcB;
        quot = (divD == '0) ? '0 : divN / divD;
        rem  = (divD == '0) ? '0 : divN % divD;
        if (signedDiv && (srcA[31] ^ srcB[31])) quot = -quot;
        if (signedDiv && srcA[31])              rem  = -rem;

        nextPendHi    = pendHi;
        nextPendLo    = pendLo;
        nextPendWrite = 1'b1;
        nextPendAcc   = ACC_NONE;
        cycles        = CNT_W'(MULT_CYCLES);
        case (op)
            MULT:  {nextPendHi, nextPendLo} = prodS;
            MULTU: {nextPendHi, nextPendLo} = prodU;
            DIV, DIVU: begin
                {nextPendHi, nextPendLo} = {rem, quot};
                nextPendWrite = (divD != '0);
                cycles        = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            MADD:  begin {nextPendHi, nextPendLo} = prodS; nextPendAcc = ACC_ADD; end
            MADDU: begin {nextPendHi, nextPendLo} = prodU; nextPendAcc = ACC_ADD; end
            MSUB:  begin {nextPendHi, nextPendLo} = prodS; nextPendAcc = ACC_SUB; end
            MSUBU: begin {nextPendHi, nextPendLo} = prodU; nextPendAcc = ACC_SUB; end
`endif
            default: nextPendWrite = 1'b0;
        endcase
    end

    md_counter #(.W(CNT_W)) uCounter (
        .clk     (clk),
        .reset   (reset),
        .load    (longAccept),
        .loadVal (cycles),
        .done    (cntDone)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (longAccept) stateNext = RUN;
            RUN:     if (cntDone)    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendWrite <= 1'b0;
            pendAcc   <= ACC_NONE;
        end else begin
            state <= stateNext;
            busy  <= (stateNext == RUN);
            if (longAccept) begin
                pendHi    <= nextPendHi;
                pendLo    <= nextPendLo;
                pendWrite <= nextPendWrite;
                pendAcc   <= nextPendAcc;
            end
            if (accept && op == MTHI) hi <= srcA;
            if (accept && op == MTLO) lo <= srcA;
            // Accumulate reads hi/lo as they stand at commit, not at accept.
            if (state == RUN && cntDone && pendWrite) begin
                case (pendAcc)
                    ACC_ADD: {hi, lo} <= {hi, lo} + {pendHi, pendLo};
                    ACC_SUB: {hi, lo} <= {hi, lo} - {pendHi, pendLo};
                    default: {hi, lo} <= {pendHi, pendLo};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, reset/req corner sequences, random ops vs. model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] srcA, srcB;
    logic [3:0]  mdOp;
    logic        start, req;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mHi, mLo;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .srcA  (srcA),
        .srcB  (srcB),
        .mdOp  (mdOp),
        .start (start),
        .req   (req),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        mdOp_e       op;
        logic [31:0] a, b;
        logic        preset;
        logic [31:0] preHi, preLo;
        logic [31:0] expHi, expLo;
        int          expCyc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input mdOp_e op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        mdOp = op; srcA = a; srcB = b; start = 1'b1; req = rq;
        step();
        start = 1'b0; req = 1'b0; mdOp = MDNOP;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 60) begin
            n++;
            step();
        end
        if (busy) check("busy timeout", 64'(busy), 64'd0);
    endtask

    task automatic runCheck(input string name, input mdOp_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic rq, input logic [31:0] eHi, input logic [31:0] eLo, input int eCyc);
        int n;
        issue(op, a, b, rq);
        waitIdle(n);
        check({name, " cycles"}, 64'(n), 64'(eCyc));
        check({name, " hi"}, 64'(hi), 64'(eHi));
        check({name, " lo"}, 64'(lo), 64'(eLo));
    endtask

    task automatic setHiLo(input logic [31:0] h, input logic [31:0] l);
        issue(MTHI, h, 32'd0, 1'b0);
        issue(MTLO, l, 32'd0, 1'b0);
        mHi = h; mLo = l;
    endtask

    // Reference: architectural result of one accepted op on the model HI/LO; returns expected busy cycles.
    function automatic int modelOp(input mdOp_e op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q, r;
        if (rq) return 0;
        case (op)
            MULT:  begin {mHi, mLo} = sa * sb; return MULT_N; end
            MULTU: begin {mHi, mLo} = ua * ub; return MULT_N; end
            DIV: begin
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    mLo = q[31:0]; mHi = r[31:0];
                end
                return DIV_N;
            end
            DIVU: begin
                if (b != 0) begin mLo = a / b; mHi = a % b; end
                return DIV_N;
            end
            MTHI: begin mHi = a; return 0; end
            MTLO: begin mLo = a; return 0; end
`ifdef MDU_MADD_EN
            MADD:  begin {mHi, mLo} = {mHi, mLo} + 64'(sa * sb); return MULT_N; end
            MADDU: begin {mHi, mLo} = {mHi, mLo} + 64'(ua * ub); return MULT_N; end
            MSUB:  begin {mHi, mLo} = {mHi, mLo} - 64'(sa * sb); return MULT_N; end
            MSUBU: begin {mHi, mLo} = {mHi, mLo} - 64'(ua * ub); return MULT_N; end
`endif
            default: return 0;
        endcase
    endfunction

    vec_t vecs[8];

    initial begin
        int n, cyc;
        mdOp_e op;
        logic [31:0] a, b;
        logic rq;

        vecs[0] = '{"mult neg", MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, MULT_N};
        vecs[1] = '{"multu", MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 0, 32'h00000001, 32'hFFFFFFFE, MULT_N};
        vecs[2] = '{"div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
        vecs[3] = '{"divu 7/2", DIVU, 32'd7, 32'd2, 1'b0, 0, 0, 32'd1, 32'd3, DIV_N};
        vecs[4] = '{"divu by 0", DIVU, 32'd7, 32'd0, 1'b1, 32'h11, 32'h22, 32'h11, 32'h22, DIV_N};
        vecs[5] = '{"div min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, 32'd0, 32'h80000000, DIV_N};
        vecs[6] = '{"div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 0, 0, 32'd1, 32'hFFFFFFFD, DIV_N};
        vecs[7] = '{"mult min*min", MULT, 32'h80000000, 32'h80000000, 1'b0, 0, 0, 32'h40000000, 32'h0, MULT_N};

        reset = 1'b1; start = 1'b0; req = 1'b0; mdOp = MDNOP; srcA = '0; srcB = '0;
        mHi = '0; mLo = '0;
        step(); step();
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        foreach (vecs[i]) begin
            if (vecs[i].preset) setHiLo(vecs[i].preHi, vecs[i].preLo);
            runCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
                     vecs[i].expHi, vecs[i].expLo, vecs[i].expCyc);
            mHi = vecs[i].expHi; mLo = vecs[i].expLo;
        end

        // MTHI suppressed by req, then accepted
        runCheck("mthi req", MTHI, 32'h1234, 32'd0, 1'b1, mHi, mLo, 0);
        runCheck("mthi", MTHI, 32'h1234, 32'd0, 1'b0, 32'h1234, mLo, 0);
        mHi = 32'h1234;
        runCheck("mult req", MULT, 32'd9, 32'd9, 1'b1, mHi, mLo, 0);

        // req and a stray start while busy: in-flight op still commits, MTHI ignored
        issue(MULT, 32'd5, 32'd6, 1'b0);
        check("busy at T+1", 64'(busy), 64'd1);
        mdOp = MTHI; srcA = 32'hDEAD; start = 1'b1; req = 1'b1;
        step();
        start = 1'b0; req = 1'b0; mdOp = MDNOP;
        waitIdle(n);
        check("req busy cycles", 64'(n + 1), 64'(MULT_N));
        check("req busy hi", 64'(hi), 64'd0);
        check("req busy lo", 64'(lo), 64'd30);

`ifndef MDU_MADD_EN
        runCheck("madd as nop", MADD, 32'd3, 32'd4, 1'b0, 32'd0, 32'd30, 0);
        runCheck("msubu as nop", MSUBU, 32'd3, 32'd4, 1'b0, 32'd0, 32'd30, 0);
`endif

        // reset during the 4th busy cycle of a DIV
        issue(DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        step(); step(); step();
        check("div 4th busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset hi", 64'(hi), 64'd0);
        check("mid reset lo", 64'(lo), 64'd0);
        step(); step(); step(); step(); step(); step(); step();
        check("no late commit", {hi, lo}, 64'd0);
        runCheck("mult 3*4", MULT, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, MULT_N);
        mHi = 32'd0; mLo = 32'd12;
`ifdef MDU_MADD_EN
        runCheck("madd 3*4", MADD, 32'd3, 32'd4, 1'b0, 32'd0, 32'd24, MULT_N);
        mHi = 32'd0; mLo = 32'd24;
        runCheck("msub 3*9", MSUB, 32'd3, 32'd9, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, MULT_N);
        mHi = 32'hFFFFFFFF; mLo = 32'hFFFFFFFD;
`endif

        for (int k = 0; k < 60; k++) begin
            op = mdOp_e'($urandom_range(1, 10));
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) b = 32'(int'($urandom_range(0, 16)) - 8);
            rq = ($urandom_range(0, 7) == 0);
            cyc = modelOp(op, a, b, rq);
            runCheck("random", op, a, b, rq, mHi, mLo, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
